// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (sequential, branch, jump,
// jump-register) with write-enable hold, plus precise exception entry/return
// via EXC_VEC, EPC, cause and exception-level flag.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   MODE_USER | normal flow; exceptions and misaligned jr are accepted
//   MODE_EXC  | inside handler (exl=1); eret returns to epc, external
//             | exceptions are masked, misaligned jr re-vectors only
module pc_unit #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]    EXC_VEC   = 'h80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWre,
  input  logic [1:0]        PCSrc,
  input  logic [15:0]       imm,
  input  logic [25:0]       jtarget,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic              exc_req,
  input  logic              eret,
  output logic [ADDR_W-1:0] currentAddress,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic [1:0]        cause,
  output logic              exl
);

  typedef enum logic {
    MODE_USER = 1'b0,
    MODE_EXC  = 1'b1
  } mode_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_EXT      = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_JR     = 2'b11;

  logic [ADDR_W-1:0] pc_q,    pc_nxt;
  logic [ADDR_W-1:0] epc_q,   epc_nxt;
  logic [1:0]        cause_q, cause_nxt;
  mode_t             mode_q,  mode_nxt;

  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] target;
  logic              misalign;
  logic              in_exc;

  assign in_exc   = (mode_q == MODE_EXC);
  assign pc_plus4 = pc_q + ADDR_W'(4);

  // Word offset sign-extended then scaled to bytes; sum wraps modulo 2^ADDR_W.
  assign br_offset = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
  assign br_target = pc_plus4 + br_offset;

  // Jump keeps the region bits above bit 27 of pc_plus4; at the minimum
  // width there are none and the target is just the shifted field.
  if (ADDR_W > 28) begin : g_jregion
    assign j_target = {pc_plus4[ADDR_W-1:28], jtarget, 2'b00};
  end else begin : g_jflat
    assign j_target = {jtarget, 2'b00};
  end

  // Only jump-register can produce an unaligned target, and only when the
  // write would actually happen.
  assign misalign = (PCSrc == SRC_JR) && PCWre && (rs_data[1:0] != 2'b00);

  // Select the normal-flow next PC from the four sources.
  always_comb begin
    target = pc_plus4;
    case (PCSrc)
      SRC_SEQ:    target = pc_plus4;
      SRC_BRANCH: target = br_target;
      SRC_JUMP:   target = j_target;
      SRC_JR:     target = rs_data;
      default:    target = pc_plus4;
    endcase
  end

  // Next-state logic; exception entry beats return beats misalign beats
  // normal flow, and masked requests fall through to the lower rules.
  always_comb begin
    pc_nxt    = pc_q;
    epc_nxt   = epc_q;
    cause_nxt = cause_q;
    mode_nxt  = mode_q;
    if (exc_req && !in_exc) begin
      pc_nxt    = EXC_VEC;
      epc_nxt   = pc_q;
      cause_nxt = CAUSE_EXT;
      mode_nxt  = MODE_EXC;
    end else if (eret && in_exc) begin
      pc_nxt    = epc_q;
      cause_nxt = CAUSE_NONE;
      mode_nxt  = MODE_USER;
    end else if (misalign) begin
      pc_nxt    = EXC_VEC;
      cause_nxt = CAUSE_MISALIGN;
      // A fault inside the handler keeps the original return address.
      if (!in_exc) begin
        epc_nxt  = pc_q;
        mode_nxt = MODE_EXC;
      end
    end else if (PCWre) begin
      pc_nxt = target;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= CAUSE_NONE;
      mode_q  <= MODE_USER;
    end else begin
      pc_q    <= pc_nxt;
      epc_q   <= epc_nxt;
      cause_q <= cause_nxt;
      mode_q  <= mode_nxt;
    end
  end

  assign currentAddress = pc_q;
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign exl            = in_exc;

endmodule
